// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS memory stage: access sizes, FSM states,
// and the lane-placement rules for byte enables and store data.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } mem_state_t;

  // The unused size code 2'b11 behaves as a word access.
  function automatic mem_size_t decodeSize(input logic [1:0] raw);
    case (raw)
      2'b00:   return MEM_BYTE;
      2'b01:   return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

  function automatic logic isMisaligned(input mem_size_t size, input logic [1:0] addrLo);
    case (size)
      MEM_HALF: return addrLo[0];
      MEM_WORD: return |addrLo;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byteEnable(input mem_size_t size, input logic [1:0] addrLo);
    case (size)
      MEM_BYTE: return 4'b0001 << addrLo;
      MEM_HALF: return addrLo[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across every lane so the memory only needs the enables.
  function automatic logic [XLEN-1:0] storeData(input mem_size_t size, input logic [XLEN-1:0] d);
    case (size)
      MEM_BYTE: return {4{d[7:0]}};
      MEM_HALF: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the
// data memory (slave). Requests are held stable until the one-cycle ack.
interface mem_stage_if;
  import mips_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// Extracts the addressed byte/half from a little-endian memory word and
// sign- or zero-extends it to 32 bits; words pass straight through.
module load_align
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addrLo,
  input  mem_size_t       size,
  input  logic            isUnsigned,
  output logic [XLEN-1:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    selByte = lane[addrLo];
    selHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];
    result  = rdata;
    case (size)
      MEM_BYTE: result = {{24{selByte[7] & ~isUnsigned}}, selByte};
      MEM_HALF: result = {{16{selHalf[15] & ~isUnsigned}}, selHalf};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues aligned loads/stores on the data-memory bus, stalls the
// pipeline until the ack, and presents registered MEM/WB results.
module mem_stage
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,

  input  logic            ex_valid,
  input  logic            ex_RegWrite,
  input  logic            ex_MemtoReg,
  input  logic            ex_MemRead,
  input  logic            ex_MemWrite,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_write_reg,
  input  logic [1:0]      ex_mem_size,
  input  logic            ex_mem_unsigned,

  output logic            mem_stall,

  mem_stage_if.master     dmem,

  output logic            wb_valid,
  output logic            wb_RegWrite,
  output logic            wb_MemtoReg,
  output logic            wb_misaligned,
  output logic [XLEN-1:0] wb_read_data,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [4:0]      wb_write_reg
);

  mem_state_t stateReg, stateNext;

  mem_size_t  exSize;
  logic       exMemOp;
  logic       exMisaligned;

  logic       issue;
  logic       fastDone;
  logic       ackDone;

  logic [XLEN-1:0] addrReg;
  logic [XLEN-1:0] wdataReg;
  logic [3:0]      beReg;
  logic            weReg;

  // Everything needed to retire the pending access, captured at issue so the
  // retirement never depends on what upstream presents during the wait.
  logic            pendRegWrite;
  logic            pendMemtoReg;
  logic            pendLoad;
  logic            pendUnsigned;
  mem_size_t       pendSize;
  logic [XLEN-1:0] pendAluResult;
  logic [4:0]      pendWriteReg;

  logic [XLEN-1:0] loadData;

  assign exSize       = decodeSize(ex_mem_size);
  assign exMemOp      = ex_valid & (ex_MemRead | ex_MemWrite);
  assign exMisaligned = exMemOp & isMisaligned(exSize, ex_alu_result[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    mem_stall = 1'b0;
    issue     = 1'b0;
    fastDone  = 1'b0;
    ackDone   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (exMemOp && !exMisaligned) begin
          mem_stall = 1'b1;
          issue     = 1'b1;
          stateNext = WAIT_ACK;
        end else if (ex_valid) begin
          fastDone = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (dmem.dmem_ack) begin
          ackDone   = 1'b1;
          stateNext = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addrReg       <= '0;
      wdataReg      <= '0;
      beReg         <= '0;
      weReg         <= 1'b0;
      pendRegWrite  <= 1'b0;
      pendMemtoReg  <= 1'b0;
      pendLoad      <= 1'b0;
      pendUnsigned  <= 1'b0;
      pendSize      <= MEM_BYTE;
      pendAluResult <= '0;
      pendWriteReg  <= '0;
      wb_valid      <= 1'b0;
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_write_reg  <= '0;
    end else begin
      wb_valid <= fastDone | ackDone;

      if (issue) begin
        addrReg       <= {ex_alu_result[XLEN-1:2], 2'b00};
        beReg         <= byteEnable(exSize, ex_alu_result[1:0]);
        wdataReg      <= storeData(exSize, ex_store_data);
        weReg         <= ex_MemWrite;
        pendRegWrite  <= ex_RegWrite;
        pendMemtoReg  <= ex_MemtoReg;
        pendLoad      <= ex_MemRead & ~ex_MemWrite;
        pendUnsigned  <= ex_mem_unsigned;
        pendSize      <= exSize;
        pendAluResult <= ex_alu_result;
        pendWriteReg  <= ex_write_reg;
      end

      // Non-memory ops and misaligned accesses retire in one cycle; a
      // misaligned access must never write the register file.
      if (fastDone) begin
        wb_RegWrite   <= ex_RegWrite & ~exMisaligned;
        wb_MemtoReg   <= ex_MemtoReg;
        wb_misaligned <= exMisaligned;
        wb_alu_result <= ex_alu_result;
        wb_write_reg  <= ex_write_reg;
      end

      if (ackDone) begin
        weReg         <= 1'b0;
        wb_RegWrite   <= pendRegWrite;
        wb_MemtoReg   <= pendMemtoReg;
        wb_misaligned <= 1'b0;
        wb_alu_result <= pendAluResult;
        wb_write_reg  <= pendWriteReg;
        if (pendLoad) begin
          wb_read_data <= loadData;
        end
      end
    end
  end

  load_align u_load_align (
    .rdata      (dmem.dmem_rdata),
    .addrLo     (pendAluResult[1:0]),
    .size       (pendSize),
    .isUnsigned (pendUnsigned),
    .result     (loadData)
  );

  assign dmem.dmem_req   = (stateReg == WAIT_ACK);
  assign dmem.dmem_we    = weReg;
  assign dmem.dmem_addr  = addrReg;
  assign dmem.dmem_be    = beReg;
  assign dmem.dmem_wdata = wdataReg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic        mem_stall;
  logic        wb_valid, wb_RegWrite, wb_MemtoReg, wb_misaligned;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_write_reg;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_RegWrite    (ex_RegWrite),
    .ex_MemtoReg    (ex_MemtoReg),
    .ex_MemRead     (ex_MemRead),
    .ex_MemWrite    (ex_MemWrite),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_write_reg   (ex_write_reg),
    .ex_mem_size    (ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned),
    .mem_stall      (mem_stall),
    .dmem           (dmem),
    .wb_valid       (wb_valid),
    .wb_RegWrite    (wb_RegWrite),
    .wb_MemtoReg    (wb_MemtoReg),
    .wb_misaligned  (wb_misaligned),
    .wb_read_data   (wb_read_data),
    .wb_alu_result  (wb_alu_result),
    .wb_write_reg   (wb_write_reg)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Observations collected while an instruction passes through the stage.
  int          obsStall;
  int          obsReq;
  logic        obsTimeout;
  logic        obsStableErr;
  logic        obsEarlyValid;
  logic        obsReqAfter;
  logic [31:0] obsAddr, obsWdata;
  logic [3:0]  obsBe;
  logic        obsWe;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic refMis(input logic [1:0] sz, input logic [31:0] addr);
    return (addr % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                          input logic [1:0] sz, input logic uns);
    int     nb;
    int     off;
    longint v;
    nb  = nbytes(sz);
    off = int'(addr[1:0]);
    v   = 0;
    for (int k = 0; k < nb; k++)
      v += longint'((rdata >> (8 * (off + k))) & 32'hFF) << (8 * k);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  function automatic logic [3:0] refBe(input logic [31:0] addr, input logic [1:0] sz);
    logic [3:0] be;
    int nb;
    int off;
    nb  = nbytes(sz);
    off = int'(addr[1:0]);
    for (int k = 0; k < 4; k++) be[k] = (k >= off) && (k < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] refWdata(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] w;
    int nb;
    nb = nbytes(sz);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % nb) +: 8];
    return w;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic runInstr(input logic rw, input logic m2r, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wreg,
                          input logic [1:0] sz, input logic uns, input int waitCycles,
                          input logic [31:0] rdata);
    logic done;
    obsStall = 0; obsReq = 0; obsTimeout = 1'b0; obsStableErr = 1'b0;
    obsEarlyValid = 1'b0; obsAddr = '0; obsBe = '0; obsWdata = '0; obsWe = 1'b0;
    done = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_RegWrite = rw; ex_MemtoReg = m2r; ex_MemRead = rd; ex_MemWrite = wr;
    ex_alu_result = alu; ex_store_data = sd; ex_write_reg = wreg; ex_mem_size = sz;
    ex_mem_unsigned = uns;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (dmem.dmem_req) begin
        if (obsReq == 0) begin
          obsAddr = dmem.dmem_addr; obsBe = dmem.dmem_be;
          obsWdata = dmem.dmem_wdata; obsWe = dmem.dmem_we;
        end else if (dmem.dmem_addr !== obsAddr || dmem.dmem_be !== obsBe ||
                     dmem.dmem_wdata !== obsWdata || dmem.dmem_we !== obsWe) begin
          obsStableErr = 1'b1;
        end
        dmem.dmem_ack   = (obsReq == waitCycles);
        dmem.dmem_rdata = (obsReq == waitCycles) ? rdata : $urandom;
        obsReq++;
      end else begin
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = $urandom;
      end
      #1;
      if (wb_valid) obsEarlyValid = 1'b1;
      if (mem_stall) obsStall++;
      else done = 1'b1;
    end
    if (!done) obsTimeout = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0; dmem.dmem_ack = 1'b0;
    #1;
    obsReqAfter = dmem.dmem_req;
    $display("[TB] txn rd=%0b wr=%0b addr=%08h size=%0d wait=%0d stall=%0d req=%0d wb_valid=%0b rdata_out=%08h",
             rd, wr, alu, sz, waitCycles, obsStall, obsReq, wb_valid, wb_read_data);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; ex_valid = 1'b0; ex_RegWrite = 1'b0; ex_MemtoReg = 1'b0; ex_MemRead = 1'b0;
    ex_MemWrite = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_write_reg = '0;
    ex_mem_size = '0; ex_mem_unsigned = 1'b0; dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({dmem.dmem_req, dmem.dmem_we, wb_valid, wb_RegWrite, wb_MemtoReg, wb_misaligned, mem_stall} !== 7'b0) begin
      failed++; $display("FAIL reset_ctrl got %b want 0",
        {dmem.dmem_req, dmem.dmem_we, wb_valid, wb_RegWrite, wb_MemtoReg, wb_misaligned, mem_stall});
    end
    tests++;
    if ({wb_read_data, wb_alu_result, wb_write_reg, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata} !== '0) begin
      failed++; $display("FAIL reset_data rd=%h alu=%h wreg=%0d addr=%h be=%b wdata=%h want 0",
        wb_read_data, wb_alu_result, wb_write_reg, dmem.dmem_addr, dmem.dmem_be, dmem.dmem_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu;
    runInstr(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 2'b10, 1'b0, 0, 32'h0);
    tests++;
    if (obsTimeout || obsStall != 0 || obsReq != 0) begin
      failed++; $display("FAIL alu_nostall stall=%0d req=%0d timeout=%0b want 0/0/0", obsStall, obsReq, obsTimeout);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_alu_result !== 32'h0000_1234 || wb_write_reg !== 5'd5 || wb_RegWrite !== 1'b1) begin
      failed++; $display("FAIL alu_wb valid=%b alu=%h wreg=%0d rw=%b want 1/00001234/5/1",
        wb_valid, wb_alu_result, wb_write_reg, wb_RegWrite);
    end
    @(negedge clk); #1;
    tests++;
    if (wb_valid !== 1'b0 || wb_alu_result !== 32'h0000_1234) begin
      failed++; $display("FAIL alu_hold valid=%b alu=%h want 0/00001234", wb_valid, wb_alu_result);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [6];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (i > 0) begin
        tests++;
        if (wb_valid !== 1'b1 || wb_alu_result !== vals[i-1] || wb_write_reg !== 5'(i - 1) || mem_stall !== 1'b0) begin
          failed++; $display("FAIL b2b_%0d valid=%b alu=%h wreg=%0d stall=%b want 1/%h/%0d/0",
            i, wb_valid, wb_alu_result, wb_write_reg, mem_stall, vals[i-1], i - 1);
        end
      end
      if (i < 5) begin
        vals[i] = $urandom;
        ex_valid = 1'b1; ex_RegWrite = 1'b1; ex_MemtoReg = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
        ex_alu_result = vals[i]; ex_write_reg = 5'(i);
        $display("[TB] txn b2b alu=%08h wreg=%0d", vals[i], i);
      end else begin
        ex_valid = 1'b0;
      end
    end
  endtask

  task automatic test_lb_sign;
    runInstr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd9, 2'b00, 1'b0, 3, 32'h8000_0000);
    tests++;
    if (obsTimeout || obsStall != 4) begin
      failed++; $display("FAIL lb_stall got %0d want 4 (timeout=%0b)", obsStall, obsTimeout);
    end
    tests++;
    if (obsAddr !== 32'h100 || obsBe !== 4'b1000 || obsWe !== 1'b0 || obsStableErr) begin
      failed++; $display("FAIL lb_bus addr=%h be=%b we=%b unstable=%b want 00000100/1000/0/0",
        obsAddr, obsBe, obsWe, obsStableErr);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_read_data !== 32'hFFFF_FF80 || obsEarlyValid || obsReqAfter !== 1'b0) begin
      failed++; $display("FAIL lb_wb valid=%b rd=%h early=%b req_after=%b want 1/ffffff80/0/0",
        wb_valid, wb_read_data, obsEarlyValid, obsReqAfter);
    end
  endtask

  task automatic test_lhu;
    runInstr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd3, 2'b01, 1'b1, 1, 32'hBEEF_0000);
    tests++;
    if (obsTimeout || obsAddr !== 32'h100 || obsBe !== 4'b1100) begin
      failed++; $display("FAIL lhu_bus addr=%h be=%b timeout=%b want 00000100/1100/0", obsAddr, obsBe, obsTimeout);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_read_data !== 32'h0000_BEEF) begin
      failed++; $display("FAIL lhu_wb valid=%b rd=%h want 1/0000beef", wb_valid, wb_read_data);
    end
  endtask

  task automatic test_sb;
    runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0201, 32'h1234_56AB, 5'd0, 2'b00, 1'b0, 0, 32'h5555_5555);
    tests++;
    if (obsTimeout || obsBe !== 4'b0010 || obsWdata !== 32'hABAB_ABAB || obsWe !== 1'b1 || obsAddr !== 32'h200) begin
      failed++; $display("FAIL sb_bus be=%b wdata=%h we=%b addr=%h want 0010/abababab/1/00000200",
        obsBe, obsWdata, obsWe, obsAddr);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_read_data !== 32'h0000_BEEF || wb_RegWrite !== 1'b0) begin
      failed++; $display("FAIL sb_wb valid=%b rd=%h rw=%b want 1/0000beef/0", wb_valid, wb_read_data, wb_RegWrite);
    end
  endtask

  task automatic test_misaligned;
    runInstr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd7, 2'b10, 1'b0, 0, 32'h0);
    tests++;
    if (obsTimeout || obsReq != 0 || obsStall != 0) begin
      failed++; $display("FAIL lw_mis_bus req=%0d stall=%0d want 0/0", obsReq, obsStall);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_misaligned !== 1'b1 || wb_RegWrite !== 1'b0 || wb_read_data !== 32'h0000_BEEF) begin
      failed++; $display("FAIL lw_mis_wb valid=%b mis=%b rw=%b rd=%h want 1/1/0/0000beef",
        wb_valid, wb_misaligned, wb_RegWrite, wb_read_data);
    end
    runInstr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 5'd8, 2'b01, 1'b0, 0, 32'h0);
    tests++;
    if (obsReq != 0 || wb_misaligned !== 1'b1 || wb_RegWrite !== 1'b0) begin
      failed++; $display("FAIL lh_mis req=%0d mis=%b rw=%b want 0/1/0", obsReq, wb_misaligned, wb_RegWrite);
    end
    runInstr(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, 5'd2, 2'b10, 1'b0, 0, 32'h0);
    tests++;
    if (wb_misaligned !== 1'b0 || wb_RegWrite !== 1'b1 || wb_alu_result !== 32'hCAFE_0001) begin
      failed++; $display("FAIL mis_clear mis=%b rw=%b alu=%h want 0/1/cafe0001", wb_misaligned, wb_RegWrite, wb_alu_result);
    end
  endtask

  task automatic test_reset_wait_ack;
    @(negedge clk);
    ex_valid = 1'b1; ex_RegWrite = 1'b1; ex_MemtoReg = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0;
    ex_alu_result = 32'h0000_0300; ex_mem_size = 2'b10; ex_mem_unsigned = 1'b0; ex_write_reg = 5'd4;
    @(negedge clk); #1;
    tests++;
    if (dmem.dmem_req !== 1'b1) begin
      failed++; $display("FAIL rstwait_req got %b want 1", dmem.dmem_req);
    end
    rst = 1'b1; ex_valid = 1'b0; dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    rst = 1'b0; dmem.dmem_ack = 1'b0; ex_MemRead = 1'b0;
    #1;
    tests++;
    if (dmem.dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
      failed++; $display("FAIL rstwait_idle req=%b valid=%b stall=%b want 0/0/0", dmem.dmem_req, wb_valid, mem_stall);
    end
    @(negedge clk);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h3333_4444;
    #1;
    tests++;
    if (mem_stall !== 1'b0) begin
      failed++; $display("FAIL stray_ack_stall got %b want 0", mem_stall);
    end
    @(negedge clk);
    dmem.dmem_ack = 1'b0;
    #1;
    tests++;
    if (wb_valid !== 1'b0 || dmem.dmem_req !== 1'b0 || wb_read_data !== 32'h0) begin
      failed++; $display("FAIL stray_ack_wb valid=%b req=%b rd=%h want 0/0/00000000", wb_valid, dmem.dmem_req, wb_read_data);
    end
    $display("[TB] txn reset during wait + stray ack");
  endtask

  task automatic test_random;
    logic [31:0] expRd;
    logic [31:0] addr, sd, rdata;
    logic [1:0]  sz;
    logic [4:0]  wreg;
    logic        uns, rw, m2r, rd, wr, mis, mem;
    int          kind, waitC, expStall;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expRd = '0;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3)); addr = $urandom; sd = $urandom; rdata = $urandom;
      uns = 1'($urandom_range(0, 1)); wreg = 5'($urandom_range(0, 31)); waitC = $urandom_range(0, 3);
      rd = (kind == 1); wr = (kind == 2);
      rw = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 1);
      m2r = (kind == 1);
      mem = rd | wr;
      mis = mem && refMis(sz, addr);
      runInstr(rw, m2r, rd, wr, addr, sd, wreg, sz, uns, waitC, rdata);
      expStall = (mem && !mis) ? waitC + 1 : 0;
      if (rd && !mis) expRd = refLoad(rdata, addr, sz, uns);
      tests++;
      if (obsTimeout || obsStall != expStall || obsReq != expStall || obsEarlyValid || obsReqAfter !== 1'b0) begin
        failed++; $display("FAIL rand%0d_flow stall=%0d req=%0d early=%b req_after=%b want %0d/%0d/0/0",
          i, obsStall, obsReq, obsEarlyValid, obsReqAfter, expStall, expStall);
      end
      tests++;
      if (wb_valid !== 1'b1 || wb_alu_result !== addr || wb_write_reg !== wreg ||
          wb_RegWrite !== (rw & ~mis) || wb_MemtoReg !== m2r || wb_misaligned !== mis) begin
        failed++; $display("FAIL rand%0d_wb valid=%b alu=%h wreg=%0d rw=%b m2r=%b mis=%b want 1/%h/%0d/%b/%b/%b",
          i, wb_valid, wb_alu_result, wb_write_reg, wb_RegWrite, wb_MemtoReg, wb_misaligned,
          addr, wreg, rw & ~mis, m2r, mis);
      end
      tests++;
      if (wb_read_data !== expRd) begin
        failed++; $display("FAIL rand%0d_rdata got %h want %h", i, wb_read_data, expRd);
      end
      if (mem && !mis) begin
        tests++;
        if (obsAddr !== {addr[31:2], 2'b00} || obsBe !== refBe(addr, sz) || obsWe !== wr || obsStableErr ||
            (wr && obsWdata !== refWdata(sd, sz))) begin
          failed++; $display("FAIL rand%0d_bus addr=%h be=%b we=%b wdata=%h unstable=%b want %h/%b/%b/%h/0",
            i, obsAddr, obsBe, obsWe, obsWdata, obsStableErr, {addr[31:2], 2'b00}, refBe(addr, sz), wr,
            refWdata(sd, sz));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_lb_sign();
    test_lhu();
    test_sb();
    test_misaligned();
    test_reset_wait_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; data and address width fixed at 32 bits.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ex_valid  in  1  EX/MEM holds a valid instruction.
REQ-005 ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite  in  1 each  control bits from EX/MEM.
REQ-006 ex_alu_result  in  32  effective address, or ALU result for non-memory ops.
REQ-007 ex_store_data  in  32  rt value for stores.
REQ-008 ex_write_reg  in  5  destination register.
REQ-009 ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 ex_mem_unsigned  in  1  zero-extend loads (LBU/LHU).
REQ-011 mem_stall  out  1  upstream holds EX/MEM contents while high.
REQ-012 dmem_req, dmem_we  out  1 each  data memory request, write enable.
REQ-013 dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 dmem_be  out  4  byte enables, little-endian.
REQ-015 dmem_wdata  out  32  lane-replicated store data.
REQ-016 dmem_ack  in  1  one-cycle completion pulse.
REQ-017 dmem_rdata  in  32  load data, valid with dmem_ack.
REQ-018 wb_valid, wb_RegWrite, wb_MemtoReg, wb_misaligned  out  1 each  MEM/WB outputs.
REQ-019 wb_read_data, wb_alu_result  out  32 each; wb_write_reg  out  5.

Function
REQ-020 FSM states IDLE, WAIT_ACK; mem op = ex_valid & (ex_MemRead | ex_MemWrite).
REQ-021 IDLE, ex_valid, no mem op: all wb_* registered next cycle (1-cycle latency), mem_stall low.
REQ-022 IDLE, aligned mem op: mem_stall high combinationally, register address/be/wdata/we, go WAIT_ACK, no wb_valid.
REQ-023 WAIT_ACK: dmem_req high; dmem_addr/be/wdata/we stable; mem_stall high until dmem_ack.
REQ-024 WAIT_ACK & dmem_ack: mem_stall low that cycle, dmem_rdata aligned and captured, wb_valid next cycle, return IDLE; dmem_req low next cycle.
REQ-025 Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]=0 -> 0011, 1 -> 1100; word 1111.
REQ-026 Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-027 Load: select lane by addr[1:0], sign-extend unless ex_mem_unsigned; word passes through.
REQ-028 Misaligned (half addr[0]=1; word addr[1:0]!=0): no dmem request, 1-cycle completion, wb_misaligned=1, wb_RegWrite=0.
REQ-029 wb_valid low in any cycle without a completing instruction; other wb_* hold last value.
REQ-030 dmem_ack in IDLE ignored; stores complete on ack with wb_read_data unchanged.

Reset
REQ-031 rst: state IDLE; dmem_req, dmem_we, wb_valid, wb_RegWrite, wb_MemtoReg, wb_misaligned 0; all data outputs 0.
REQ-032 rst in WAIT_ACK abandons the access; a later ack for it is ignored per REQ-030.
REQ-033 rst dominates a same-cycle dmem_ack.

Structure
REQ-034 Shared package mips_pkg holds mem_size_t (MEM_BYTE, MEM_HALF, MEM_WORD) and mem_state_t.
REQ-035 One combinational sub-module load_align (rdata, addr[1:0], size, unsigned -> 32-bit result).

Verification
REQ-036 ALU op, alu_result=0x0000_1234, write_reg=5 -> next cycle wb_valid=1, wb_alu_result=0x1234, no dmem_req.
REQ-037 LB addr=0x103, rdata=0x80_00_00_00, ack after 3 wait cycles -> mem_stall 4 cycles, wb_read_data=0xFFFF_FF80.
REQ-038 LHU addr=0x102, rdata=0xBEEF_0000 -> dmem_addr=0x100, wb_read_data=0x0000_BEEF.
REQ-039 SB addr=0x201, data=0xAB -> dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1.
REQ-040 LW addr=0x102 -> no dmem_req, wb_misaligned=1, wb_RegWrite=0 next cycle.
REQ-041 rst asserted in WAIT_ACK, then ack -> IDLE, dmem_req 0, wb_valid stays 0.
